// File: rtl/bnn_uart_pkg.sv
// rtl/bnn_uart_pkg.sv - shared types and constants for the BNN UART receive path
package bnn_uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/bnn_uart_rx_if.sv
// rtl/bnn_uart_rx_if.sv - byte stream from the UART receiver to the BNN controller
interface bnn_uart_rx_if import bnn_uart_pkg::*; ();

    logic [UART_DATA_BITS-1:0] m_data;
    logic                      m_valid;
    logic                      m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/bnn_byte_fifo.sv
// rtl/bnn_byte_fifo.sv - small synchronous byte FIFO with simultaneous push/pop at full
module bnn_byte_fifo import bnn_uart_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [CW-1:0]             count_next
);

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [CW-1:0]             count;
    logic                      pop_ok;
    logic                      push_ok;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign pop_ok     = pop & ~empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_ok    = push & (~full | pop_ok);
    assign count_next = count + CW'(push_ok) - CW'(pop_ok);
    assign pop_data   = empty ? '0 : mem[rd_ptr];

    // Pointer, occupancy and storage update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/bnn_uart_rx.sv
// rtl/bnn_uart_rx.sv - oversampling 8N1 UART receiver with byte FIFO and CTS throttle
module bnn_uart_rx import bnn_uart_pkg::*; #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    bnn_uart_rx_if.master        m_if,
    output logic                 cts_n,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int IW  = $clog2(UART_DATA_BITS);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

    logic                      rx_meta;
    logic                      rx_s;
    rx_state_e                 state;
    logic [CW-1:0]             bit_cnt;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      push;
    logic                      pop_ok;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [FCW-1:0]            count_next;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Deframing FSM: mid-start qualification, mid-bit data sampling, stop check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt        <= '0;
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + IW'(1);
                        if (bit_idx == IDX_LAST) state <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    bit_cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push   = (state == STOP) && (bit_cnt == BIT_LAST) && rx_s;
    assign pop_ok = m_if.m_valid & m_if.m_ready;
    assign busy   = (state != IDLE);

    bnn_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (shift),
        .pop        (m_if.m_ready),
        .pop_data   (m_if.m_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count_next (count_next)
    );

    assign m_if.m_valid = ~fifo_empty;

    // Flow-control and drop reporting; CTS keeps one slot spare for an in-flight byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cts_n   <= 1'b1;
            overrun <= 1'b0;
        end else begin
            cts_n   <= (count_next >= FCW'(FIFO_DEPTH - 1));
            overrun <= push & fifo_full & ~pop_ok;
        end
    end

endmodule

// File: tb/tb_bnn_uart_rx.sv
// tb/tb_bnn_uart_rx.sv - self-checking bench for bnn_uart_rx
module tb_bnn_uart_rx;
    import bnn_uart_pkg::*;

    localparam int CPB        = 8;
    localparam int DEPTH      = 4;
    localparam int SAMPLE_OFS = 3 + CPB / 2 + 9 * CPB;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         hold;
        int         exp_ferr;
        int         exp_bytes;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_i  = 1'b1;
    logic cts_n, frame_err, overrun, busy;

    bnn_uart_rx_if sif ();

    bnn_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (rx_i),
        .m_if      (sif),
        .cts_n     (cts_n),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q[$];
    int   ferr_cnt = 0, ovr_cnt = 0, valid_cycles = 0, valid_rise = -1;
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = '0;

    bit rand_ready = 0;
    int pulse_at   = -1;
    int rst_at     = -1;
    int c0         = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (sif.m_valid && sif.m_ready) got_q.push_back(sif.m_data);
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (sif.m_valid) valid_cycles++;
        if (sif.m_valid && !prev_valid) valid_rise = cyc;
        if (prev_valid && !prev_ready && sif.m_valid) chk("m_data_hold", sif.m_data, prev_data);
        prev_valid = sif.m_valid;
        prev_ready = sif.m_ready;
        prev_data  = sif.m_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) sif.m_ready = 1'($urandom_range(0, 1));
        if (pulse_at >= 0) sif.m_ready = (cyc == pulse_at);
        if (rst_at >= 0) rst_n = (cyc != rst_at);
    endtask

    task automatic clear_mon();
        got_q.delete();
        ferr_cnt     = 0;
        ovr_cnt      = 0;
        valid_cycles = 0;
        valid_rise   = -1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int hold,
                              input bit pulse, input int rst_off);
        rx_i = 1'b0;
        c0   = cyc;
        if (pulse) pulse_at = c0 + SAMPLE_OFS - 1;
        if (rst_off >= 0) rst_at = c0 + rst_off;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (CPB) tick();
        end
        rx_i = stop;
        repeat (CPB) tick();
        repeat (hold) tick();
        rx_i = 1'b1;
        repeat (3 * CPB) tick();
        if (pulse) begin
            pulse_at     = -1;
            sif.m_ready  = 1'b0;
        end
        rst_at = -1;
    endtask

    vec_t       tbl[6];
    logic [7:0] exp_q[$];
    logic [7:0] exp_got[$];
    int         exp_ferr, exp_ovr, occ;

    initial begin
        sif.m_ready = 1'b1;
        tbl[0] = '{8'hA5, 1'b1, 0,  0, 1};
        tbl[1] = '{8'h00, 1'b1, 0,  0, 1};
        tbl[2] = '{8'hFF, 1'b1, 0,  0, 1};
        tbl[3] = '{8'h3C, 1'b0, 40, 1, 0};
        tbl[4] = '{8'h81, 1'b1, 0,  0, 1};
        tbl[5] = '{8'h5A, 1'b0, 0,  1, 0};

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", sif.m_valid, 0);
        chk("rst_m_data", sif.m_data, 0);
        chk("rst_cts_n", cts_n, 1);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("cts_after_release", cts_n, 0);
        repeat (4) tick();

        // table of single frames with the consumer always ready
        for (int v = 0; v < 6; v++) begin
            clear_mon();
            send_frame(tbl[v].d, tbl[v].stop, tbl[v].hold, 0, -1);
            chk("tbl_ferr", ferr_cnt, tbl[v].exp_ferr);
            chk("tbl_ovr", ovr_cnt, 0);
            chk("tbl_nbytes", got_q.size(), tbl[v].exp_bytes);
            if (tbl[v].exp_bytes == 1 && got_q.size() == 1) begin
                chk("tbl_data", got_q[0], tbl[v].d);
                chk("tbl_latency", valid_rise, c0 + SAMPLE_OFS);
                chk("tbl_valid_len", valid_cycles, 1);
            end
        end

        // start-bit glitch shorter than half a bit
        clear_mon();
        rx_i = 1'b0;
        c0   = cyc;
        repeat (3) tick();
        rx_i = 1'b1;
        while (cyc < c0 + 6) tick();
        chk("glitch_busy_start", busy, 1);
        tick();
        chk("glitch_busy_idle", busy, 0);
        repeat (3 * CPB) tick();
        chk("glitch_ferr", ferr_cnt, 0);
        chk("glitch_nbytes", got_q.size(), 0);

        // overflow with the consumer stalled, then drain
        clear_mon();
        sif.m_ready = 1'b0;
        exp_q.delete();
        exp_ovr = 0;
        for (int k = 1; k <= 5; k++) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(k));
            else exp_ovr++;
            send_frame(8'(k), 1'b1, 0, 0, -1);
            occ = exp_q.size();
            chk("ovf_cts_n", cts_n, (occ >= DEPTH - 1));
            chk("ovf_m_valid", sif.m_valid, 1);
            chk("ovf_head", sif.m_data, 8'h01);
        end
        chk("ovf_overrun", ovr_cnt, exp_ovr);
        sif.m_ready = 1'b1;
        repeat (8) tick();
        sif.m_ready = 1'b0;
        chk("ovf_drain_n", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("ovf_drain_data", got_q[i], exp_q[i]);
        chk("ovf_cts_empty", cts_n, 0);

        // full FIFO with a pop in the exact push cycle
        clear_mon();
        exp_q.delete();
        exp_got.delete();
        for (int k = 0; k < DEPTH; k++) begin
            exp_q.push_back(8'h10 + 8'(k));
            send_frame(8'h10 + 8'(k), 1'b1, 0, 0, -1);
        end
        exp_got.push_back(exp_q.pop_front());
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 0, 1, -1);
        chk("fullpop_overrun", ovr_cnt, 0);
        chk("fullpop_popped", got_q.size(), 1);
        chk("fullpop_cts_n", cts_n, 1);
        while (exp_q.size() > 0) exp_got.push_back(exp_q.pop_front());
        sif.m_ready = 1'b1;
        repeat (8) tick();
        chk("fullpop_total", got_q.size(), exp_got.size());
        for (int i = 0; i < exp_got.size() && i < got_q.size(); i++)
            chk("fullpop_order", got_q[i], exp_got[i]);

        // reset during data bit 4 clears a buffered byte and aborts the frame
        clear_mon();
        sif.m_ready = 1'b0;
        send_frame(8'h42, 1'b1, 0, 0, -1);
        chk("rstmid_pre_valid", sif.m_valid, 1);
        send_frame(8'hF0, 1'b1, 0, 0, 4 * CPB + CPB + CPB / 2);
        chk("rstmid_m_valid", sif.m_valid, 0);
        chk("rstmid_m_data", sif.m_data, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_cts_n", cts_n, 0);
        chk("rstmid_ferr", ferr_cnt, 0);
        clear_mon();
        sif.m_ready = 1'b1;
        send_frame(8'h7E, 1'b1, 0, 0, -1);
        chk("rstmid_next_n", got_q.size(), 1);
        if (got_q.size() == 1) chk("rstmid_next_data", got_q[0], 8'h7E);

        // randomized frames and a randomly stalling consumer
        clear_mon();
        exp_got.delete();
        exp_ferr   = 0;
        rand_ready = 1;
        for (int n = 0; n < 15; n++) begin
            logic [7:0] d;
            logic       stop;
            int         hold;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            hold = stop ? 0 : int'($urandom_range(0, 20));
            if (stop) exp_got.push_back(d);
            else exp_ferr++;
            send_frame(d, stop, hold, 0, -1);
        end
        rand_ready  = 0;
        sif.m_ready = 1'b1;
        repeat (10) tick();
        chk("rand_ferr", ferr_cnt, exp_ferr);
        chk("rand_ovr", ovr_cnt, 0);
        chk("rand_nbytes", got_q.size(), exp_got.size());
        for (int i = 0; i < exp_got.size() && i < got_q.size(); i++)
            chk("rand_data", got_q[i], exp_got[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
